// File: rtl/cofre_supervisor_pkg.sv
// Shared definitions for the safe keypad supervisor: state codes, key codes, helpers.
package cofre_supervisor_pkg;

    localparam logic [1:0] ST_ENTRADA  = 2'b00;
    localparam logic [1:0] ST_ABERTO   = 2'b01;
    localparam logic [1:0] ST_BLOQUEIO = 2'b10;

    localparam logic [1:0] DIG_NADA = 2'b00;
    localparam logic [1:0] DIG_A    = 2'b01;
    localparam logic [1:0] DIG_B    = 2'b10;
    localparam logic [1:0] DIG_C    = 2'b11;

    // Digit 0 lives in the top two bits; out-of-range positions never match a real key.
    function automatic logic [1:0] senha_digito(input logic [9:0] senha, input logic [2:0] idx);
        case (idx)
            3'd0:    return senha[9:8];
            3'd1:    return senha[7:6];
            3'd2:    return senha[5:4];
            3'd3:    return senha[3:2];
            3'd4:    return senha[1:0];
            default: return DIG_NADA;
        endcase
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/cofre_temporizador.sv
// Loadable down-counter shared by the open, lockout and inactivity timeouts.
module cofre_temporizador #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         carga,
    input  logic [W-1:0] valor,
    input  logic         conta,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    // Load wins over count; the counter parks at zero instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else if (carga)
            cnt_q <= valor;
        else if (conta && (cnt_q != '0))
            cnt_q <= cnt_q - 1'b1;
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/cofre_supervisor.sv
// Safe keypad supervisor: press detection, digit-by-digit password check,
// failure counting with timed lockout, auto-relock and abandon-on-idle.
module cofre_supervisor
    import cofre_supervisor_pkg::*;
#(
    parameter logic [9:0] SENHA      = 10'b11_10_01_10_11,
    parameter int         MAX_FALHAS = 3,
    parameter int         T_ABERTO   = 1000,
    parameter int         T_BLOQUEIO = 5000,
    parameter int         T_INATIVO  = 2000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] digito,
    input  logic       fechar,
    output logic       aberto,
    output logic       bloqueado,
    output logic [2:0] progresso,
    output logic [1:0] falhas,
    output logic       erro
);

    localparam int T_MAX = max3(T_ABERTO, T_BLOQUEIO, T_INATIVO);
    localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;
    localparam logic [2:0] FALHAS_MAX = 3'(MAX_FALHAS);

    logic [1:0] state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [1:0] falhas_q, falhas_d;
    logic       erro_q, erro_d;
    logic [1:0] d_prev_q;

    logic          ev;
    logic          carga, conta, zero;
    logic [TW-1:0] valor;

    // A press is a nonzero code following a sampled 00; held or rolled keys do not retrigger.
    assign ev = (digito != DIG_NADA) && (d_prev_q == DIG_NADA);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        falhas_d = falhas_q;
        erro_d   = 1'b0;
        carga    = 1'b0;
        conta    = 1'b0;
        valor    = '0;
        case (state_q)
            ST_ENTRADA: begin
                if (ev) begin
                    if (digito == senha_digito(SENHA, idx_q)) begin
                        if (idx_q == 3'd4) begin
                            state_d  = ST_ABERTO;
                            idx_d    = 3'd0;
                            falhas_d = 2'd0;
                            carga    = 1'b1;
                            valor    = TW'(T_ABERTO - 1);
                        end else begin
                            idx_d = idx_q + 3'd1;
                            carga = 1'b1;
                            valor = TW'(T_INATIVO - 1);
                        end
                    end else begin
                        erro_d = 1'b1;
                        idx_d  = 3'd0;
                        if ({1'b0, falhas_q} < FALHAS_MAX)
                            falhas_d = falhas_q + 2'd1;
                        if ({1'b0, falhas_q} + 3'd1 == FALHAS_MAX) begin
                            state_d = ST_BLOQUEIO;
                            carga   = 1'b1;
                            valor   = TW'(T_BLOQUEIO - 1);
                        end
                    end
                end else if (idx_q != 3'd0) begin
                    // Partial entry: abandon silently once the idle window runs out.
                    if (zero)
                        idx_d = 3'd0;
                    else
                        conta = 1'b1;
                end
            end
            ST_ABERTO: begin
                if (fechar || zero) begin
                    state_d = ST_ENTRADA;
                    idx_d   = 3'd0;
                end else begin
                    conta = 1'b1;
                end
            end
            ST_BLOQUEIO: begin
                if (zero) begin
                    state_d  = ST_ENTRADA;
                    idx_d    = 3'd0;
                    falhas_d = 2'd0;
                end else begin
                    conta = 1'b1;
                end
            end
            default: begin
                state_d = ST_ENTRADA;
                idx_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_ENTRADA;
            idx_q    <= 3'd0;
            falhas_q <= 2'd0;
            erro_q   <= 1'b0;
            d_prev_q <= DIG_NADA;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            falhas_q <= falhas_d;
            erro_q   <= erro_d;
            d_prev_q <= digito;
        end
    end

    cofre_temporizador #(.W(TW)) u_temporizador (
        .clk   (clk),
        .reset (reset),
        .carga (carga),
        .valor (valor),
        .conta (conta),
        .zero  (zero)
    );

    assign aberto    = (state_q == ST_ABERTO);
    assign bloqueado = (state_q == ST_BLOQUEIO);
    assign progresso = idx_q;
    assign falhas    = falhas_q;
    assign erro      = erro_q;

endmodule

// File: tb/tb_cofre_supervisor.sv
// Directed scoreboard bench for cofre_supervisor with short timeouts.
module tb_cofre_supervisor;

    localparam logic [1:0] K0 = 2'b00;
    localparam logic [1:0] KA = 2'b01;
    localparam logic [1:0] KB = 2'b10;
    localparam logic [1:0] KC = 2'b11;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] digito;
    logic       fechar;
    logic       aberto, bloqueado, erro;
    logic [2:0] progresso;
    logic [1:0] falhas;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    cofre_supervisor #(
        .SENHA      (10'b11_10_01_10_11),
        .MAX_FALHAS (3),
        .T_ABERTO   (8),
        .T_BLOQUEIO (16),
        .T_INATIVO  (10)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .digito    (digito),
        .fechar    (fechar),
        .aberto    (aberto),
        .bloqueado (bloqueado),
        .progresso (progresso),
        .falhas    (falhas),
        .erro      (erro)
    );

    always #5 clk = ~clk;

    // Expected output vector {aberto, bloqueado, progresso, falhas, erro}.
    function automatic logic [7:0] o(input bit ab, input bit bl, input int pr, input int fa, input bit er);
        return {ab, bl, 3'(pr), 2'(fa), er};
    endfunction

    task automatic chk(input string tag);
        logic [7:0] e, obs;
        e   = exp_q.pop_front();
        obs = {aberto, bloqueado, progresso, falhas, erro};
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, e);
        end
    endtask

    // Called just after a falling edge: drive, expect, sample after the next rising edge.
    task automatic st(input string tag, input logic [1:0] d, input logic f, input logic [7:0] e);
        digito = d;
        fechar = f;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        chk(tag);
        @(negedge clk);
    endtask

    task automatic hold(input string tag, input logic [1:0] d, input logic f, input int n, input logic [7:0] e);
        for (int i = 0; i < n; i++) st(tag, d, f, e);
    endtask

    task automatic code_open(input string tag);
        st({tag, "_c1"}, KC, 1'b0, o(0, 0, 1, 0, 0));
        st({tag, "_g1"}, K0, 1'b0, o(0, 0, 1, 0, 0));
        st({tag, "_b2"}, KB, 1'b0, o(0, 0, 2, 0, 0));
        st({tag, "_g2"}, K0, 1'b0, o(0, 0, 2, 0, 0));
        st({tag, "_a3"}, KA, 1'b0, o(0, 0, 3, 0, 0));
        st({tag, "_g3"}, K0, 1'b0, o(0, 0, 3, 0, 0));
        st({tag, "_b4"}, KB, 1'b0, o(0, 0, 4, 0, 0));
        st({tag, "_g4"}, K0, 1'b0, o(0, 0, 4, 0, 0));
        st({tag, "_open"}, KC, 1'b0, o(1, 0, 0, 0, 0));
    endtask

    task automatic three_wrong(input string tag);
        st({tag, "_w1"}, KA, 1'b0, o(0, 0, 0, 1, 1));
        st({tag, "_g1"}, K0, 1'b0, o(0, 0, 0, 1, 0));
        st({tag, "_w2"}, KA, 1'b0, o(0, 0, 0, 2, 1));
        st({tag, "_g2"}, K0, 1'b0, o(0, 0, 0, 2, 0));
        st({tag, "_w3"}, KA, 1'b0, o(0, 1, 0, 3, 1));
    endtask

    task automatic async_reset(input string tag);
        #1 reset = 1'b1;
        #1;
        exp_q.push_back(o(0, 0, 0, 0, 0));
        chk(tag);
        #1 reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] lock_keys [15];
        reset  = 1'b1;
        digito = K0;
        fechar = 1'b0;
        #3;
        exp_q.push_back(o(0, 0, 0, 0, 0));
        chk("reset");
        @(negedge clk);
        reset = 1'b0;

        // 1: correct code opens, auto-relock after 8 cycles
        code_open("t1");
        hold("t1_open", K0, 1'b0, 7, o(1, 0, 0, 0, 0));
        st("t1_relock", K0, 1'b0, o(0, 0, 0, 0, 0));

        // 2: fechar on open cycle 3; held key across exit makes no event
        code_open("t2");
        st("t2_open2", K0, 1'b0, o(1, 0, 0, 0, 0));
        st("t2_close", K0, 1'b1, o(0, 0, 0, 0, 0));
        code_open("t2b");
        hold("t2_heldC", KC, 1'b0, 3, o(1, 0, 0, 0, 0));
        st("t2_closeC", KC, 1'b1, o(0, 0, 0, 0, 0));
        st("t2_stillC", KC, 1'b0, o(0, 0, 0, 0, 0));
        st("t2_rel", K0, 1'b0, o(0, 0, 0, 0, 0));
        st("t2_repress", KC, 1'b0, o(0, 0, 1, 0, 0));
        st("t2_g", K0, 1'b0, o(0, 0, 1, 0, 0));

        // 3: held key is one event; rolling C->B without 00 is no event
        st("t3_b", KB, 1'b0, o(0, 0, 2, 0, 0));
        st("t3_g", K0, 1'b0, o(0, 0, 2, 0, 0));
        hold("t3_heldA", KA, 1'b0, 5, o(0, 0, 3, 0, 0));
        st("t3_relA", K0, 1'b0, o(0, 0, 3, 0, 0));
        st("t3_b4", KB, 1'b0, o(0, 0, 4, 0, 0));
        st("t3_g4", K0, 1'b0, o(0, 0, 4, 0, 0));
        st("t3_open", KC, 1'b0, o(1, 0, 0, 0, 0));
        st("t3_close", K0, 1'b1, o(0, 0, 0, 0, 0));
        st("t3_c", KC, 1'b0, o(0, 0, 1, 0, 0));
        st("t3_roll", KB, 1'b0, o(0, 0, 1, 0, 0));
        st("t3_rg", K0, 1'b0, o(0, 0, 1, 0, 0));
        st("t3_b2", KB, 1'b0, o(0, 0, 2, 0, 0));

        // 5: idle abandon after 10 cycles; press on the 10th idle cycle wins
        hold("t5_idle", K0, 1'b0, 9, o(0, 0, 2, 0, 0));
        st("t5_expire", K0, 1'b0, o(0, 0, 0, 0, 0));
        st("t5_c", KC, 1'b0, o(0, 0, 1, 0, 0));
        st("t5_g", K0, 1'b0, o(0, 0, 1, 0, 0));
        st("t5_b", KB, 1'b0, o(0, 0, 2, 0, 0));
        hold("t5_idle9", K0, 1'b0, 9, o(0, 0, 2, 0, 0));
        st("t5_race", KA, 1'b0, o(0, 0, 3, 0, 0));
        hold("t5_idle3", K0, 1'b0, 9, o(0, 0, 3, 0, 0));
        st("t5_expire3", K0, 1'b0, o(0, 0, 0, 0, 0));

        // 4: three wrong digits lock for 16 cycles, entry ignored meanwhile
        three_wrong("t4");
        lock_keys = '{KC, K0, KB, K0, KA, K0, KB, K0, KC, K0, K0, K0, K0, K0, K0};
        for (int i = 0; i < 15; i++) st("t4_locked", lock_keys[i], 1'b1, o(0, 1, 0, 3, 0));
        st("t4_unlock", K0, 1'b0, o(0, 0, 0, 0, 0));
        code_open("t4");
        st("t4_close", K0, 1'b1, o(0, 0, 0, 0, 0));

        // 6: asynchronous reset mid-lockout and mid-open
        three_wrong("t6");
        st("t6_locked", K0, 1'b0, o(0, 1, 0, 3, 0));
        async_reset("t6_rst_lock");
        code_open("t6");
        st("t6_open2", K0, 1'b0, o(1, 0, 0, 0, 0));
        async_reset("t6_rst_open");
        code_open("t6b");
        st("t6_close", K0, 1'b1, o(0, 0, 0, 0, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
